control_sequencer: RTL
======================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter OPW, default 5, opcode width in bits.
REQ-002 Parameter CW, default 32, control-word width in bits; field offsets come from the shared package.
REQ-003 Parameter CNTW, default 16, retired-instruction counter width.
REQ-004 Port CLK  in  1  single system clock; all state changes occur on its rising edge.
REQ-005 Port Reset  in  1  asynchronous, active-low reset (Reset=0 resets).
REQ-006 Port OPCODE  in  OPW  opcode field from the instruction register.
REQ-007 Port flagbit  in  1  immediate/indirect ("@") mode bit from the instruction register.
REQ-008 Port mem_ready  in  1  memory acknowledge; 1 = current access completes this cycle.
REQ-009 Port run_en  in  1  run enable; sampled only in FETCH.
REQ-010 Port ctrl  out  CW  packed control word: MemRead, MemWrite, MemSrc, MemDst, Mary/Shelley/Comp/RA/PC/SP/Inst write enables, source selects, SrcA, SrcB, ALUOP.
REQ-011 Port state  out  3  current FSM state encoding.
REQ-012 Port instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
REQ-013 Port illegal  out  1  sticky illegal-opcode flag.
REQ-014 Port halted  out  1  1 while in HALT.
REQ-015 Port retired  out  CNTW  count of completed instructions.

Function
REQ-016 States: FETCH=0, DECODE=1, EXEC=2, WB=3, HALT=4; all other encodings SHALL go to FETCH on the next edge.
REQ-017 FETCH: hold with ctrl=0 while run_en=0. With run_en=1, ctrl SHALL present a memory read at PC. PCWrite (PCSrc=000) and InstWrite assert only in the cycle mem_ready=1, and the FSM then moves to DECODE; otherwise it holds in FETCH.
REQ-018 DECODE: ctrl=0. {OPCODE, flagbit} SHALL be latched into internal op_q. Class lookup: HALT opcode (all ones) -> HALT; illegal -> HALT with illegal set; otherwise -> EXEC.
REQ-019 Classes (OPW=5): ONE = 0x00, 0x07-0x0B, 0x17; MEMW = 0x01, 0x14-0x16; MEMR = 0x04-0x06, 0x13; ALU = 0x02, 0x03, 0x0C-0x12; illegal = 0x18-0x1E.
REQ-020 EXEC, ONE: ctrl SHALL assert the instruction's register/PC writes for one cycle; next state FETCH; instr_done=1.
REQ-021 EXEC, MEMW/MEMR: the memory fields SHALL be held stable while mem_ready=0. MemWrite and SPWrite assert only in the mem_ready=1 cycle, so each write occurs exactly once. On mem_ready=1, MEMW -> FETCH with instr_done=1; MEMR -> WB.
REQ-022 EXEC, ALU: ctrl SHALL present SrcA, SrcB and ALUOP only, with no write enables; next state WB.
REQ-023 WB: ctrl SHALL assert the destination write (MaryWrite/ShelleyWrite/CompWrite/RAWrite, plus SPWrite for pops); next state FETCH; instr_done=1.
REQ-024 ctrl is a function of state and op_q only, never of live OPCODE after DECODE.
REQ-025 Latency with zero wait states: ONE = 3 cycles, MEMW = 3, ALU = 4, MEMR = 4. Each mem_ready=0 cycle adds one cycle.
REQ-026 retired SHALL increment by 1 on every instr_done and wrap from 2^CNTW-1 to 0.
REQ-027 HALT: ctrl=0 and halted=1. HALT is left only by reset; run_en and mem_ready are ignored.
REQ-028 illegal SHALL set in the DECODE cycle of an illegal opcode and clear only on reset.

Reset
REQ-029 Reset=0 SHALL immediately (asynchronously) force state=FETCH, op_q=0, retired=0, illegal=0, instr_done=0 and ctrl=0, including mid-EXEC or mid-wait.
REQ-030 After Reset deasserts, the first active edge SHALL evaluate FETCH normally; no partial write of an interrupted instruction is ever re-issued.

Structure
REQ-031 Shared package cs_pkg SHALL hold the state encodings, class enumeration, ctrl field offsets/widths, the HALT opcode and the opcode-to-class table.
REQ-032 Combinational sub-module cs_decode SHALL map {op_q, flagbit, state, mem_ready} to ctrl. control_sequencer holds only the FSM, latch, counter and flags.

Verification
REQ-033 AADD (0x02, flag=0), mem_ready=1 -> states 0,1,2,3,0. ALUOP=0010 in EXEC; MaryWrite=1, MarySrc=01 in WB; retired 0->1.
REQ-034 SPUT (0x01) with mem_ready low for 3 EXEC cycles -> ctrl memory fields stable. MemWrite=1 and SPWrite=1 exactly once; total 6 cycles.
REQ-035 Opcode 0x1A -> illegal=1 and halted=1 from the cycle after DECODE. ctrl stays 0 for 10 further cycles with run_en toggling.
REQ-036 Reset pulsed low during MEMR EXEC wait -> ctrl=0 and state=0 without a clock edge. The next SPOP (0x05) completes with MaryWrite=1 once.
REQ-037 CNTW=4: 17 JRET (0x0A) instructions -> retired reads 0 after the 16th and 1 after the 17th. Each takes 3 cycles.
REQ-038 run_en=0 in FETCH for 5 cycles -> no PCWrite or InstWrite. Fetch proceeds in the cycle after run_en rises, given mem_ready=1.

Source files
------------

// File: rtl/cs_pkg.sv
// Shared definitions for the control sequencer: state codes, opcode
// classes, control-word field layout and the opcode-to-class table.
package cs_pkg;

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_WB     = 3'd3;
   localparam logic [2:0] S_HALT   = 3'd4;

   typedef enum logic [2:0] {
      CLS_ONE,
      CLS_MEMW,
      CLS_MEMR,
      CLS_ALU,
      CLS_HALT,
      CLS_ILL
   } cls_e;

   localparam int F_MEMREAD  = 0;
   localparam int F_MEMWRITE = 1;
   localparam int F_MEMSRC   = 2;
   localparam int F_MEMDST   = 4;
   localparam int F_MARYW    = 6;
   localparam int F_SHELW    = 7;
   localparam int F_COMPW    = 8;
   localparam int F_RAW      = 9;
   localparam int F_PCW      = 10;
   localparam int F_SPW      = 11;
   localparam int F_INSTW    = 12;
   localparam int F_MARYSRC  = 13;
   localparam int F_SHELSRC  = 15;
   localparam int F_SPSRC    = 17;
   localparam int F_PCSRC    = 19;
   localparam int F_SRCA     = 22;
   localparam int F_SRCB     = 24;
   localparam int F_ALUOP    = 26;
   localparam int CTRL_W     = 30;

   localparam logic [4:0] HALT_OP = 5'h1F;

   function automatic cls_e op_class(input logic [7:0] op);
      cls_e c;
      case (op)
         8'h00, 8'h07, 8'h08, 8'h09,
         8'h0A, 8'h0B, 8'h17:         c = CLS_ONE;
         8'h01, 8'h14, 8'h15, 8'h16:  c = CLS_MEMW;
         8'h04, 8'h05, 8'h06, 8'h13:  c = CLS_MEMR;
         8'h02, 8'h03, 8'h0C, 8'h0D,
         8'h0E, 8'h0F, 8'h10, 8'h11,
         8'h12:                       c = CLS_ALU;
         {3'b000, HALT_OP}:           c = CLS_HALT;
         default:                     c = CLS_ILL;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/control_sequencer_decode.sv
// Combinational control-word generator: maps latched opcode, state and
// memory handshake onto the packed datapath control word.
module cs_decode
   import cs_pkg::*;
#(
   parameter int OPW = 5,
   parameter int CW  = 32
) (
   input  logic [OPW:0]  i_op_q,
   input  logic [2:0]    i_state,
   input  logic          i_run_en,
   input  logic          i_mem_ready,
   output logic [CW-1:0] o_ctrl
);

   logic [7:0]        w_op;
   logic              w_flag;
   cls_e              w_cls;
   logic [CTRL_W-1:0] w_c;

   assign w_op   = 8'(i_op_q[OPW:1]);
   assign w_flag = i_op_q[0];
   assign w_cls  = op_class(w_op);
   assign o_ctrl = CW'(w_c);

   always_comb begin
      w_c = '0;
      unique case (1'b1)
         (i_state == S_FETCH): begin
            if (i_run_en) begin
               w_c[F_MEMREAD] = 1'b1;
               if (i_mem_ready) begin
                  w_c[F_PCW]   = 1'b1;
                  w_c[F_INSTW] = 1'b1;
               end
            end
         end
         (i_state == S_EXEC): begin
            case (w_cls)
               CLS_ONE: begin
                  if (w_op == 8'h17) begin
                     w_c[F_PCW]           = 1'b1;
                     w_c[F_RAW]           = 1'b1;
                     w_c[F_PCSRC +: 3]    = 3'd6;
                  end else if (w_op != 8'h00) begin
                     w_c[F_PCW]           = 1'b1;
                     w_c[F_PCSRC +: 3]    = 3'(w_op - 8'd6);
                  end
               end
               CLS_MEMW: begin
                  w_c[F_MEMSRC +: 2] = w_flag ? 2'b11 :
                                       (w_op == 8'h01) ? 2'b01 : 2'b10;
                  w_c[F_MEMDST +: 2] = (w_op == 8'h01) ? 2'b01 : 2'b10;
                  // Write strobes only on the acknowledge cycle
                  if (i_mem_ready) begin
                     w_c[F_MEMWRITE] = 1'b1;
                     if (w_op == 8'h01) begin
                        w_c[F_SPW]        = 1'b1;
                        w_c[F_SPSRC +: 2] = 2'b01;
                     end
                  end
               end
               CLS_MEMR: begin
                  w_c[F_MEMREAD]     = 1'b1;
                  w_c[F_MEMSRC +: 2] = w_flag ? 2'b11 :
                                       (w_op == 8'h05) ? 2'b01 : 2'b10;
                  w_c[F_MEMDST +: 2] = 2'b11;
               end
               CLS_ALU: begin
                  w_c[F_SRCA +: 2]  = 2'b00;
                  w_c[F_SRCB +: 2]  = w_flag ? 2'b10 : 2'b01;
                  w_c[F_ALUOP +: 4] = w_op[3:0];
               end
               default: ;
            endcase
         end
         (i_state == S_WB): begin
            case (w_cls)
               CLS_ALU: begin
                  if (w_op >= 8'h0C && w_op <= 8'h0F) begin
                     w_c[F_COMPW] = 1'b1;
                  end else if (w_op >= 8'h10) begin
                     w_c[F_SHELW]        = 1'b1;
                     w_c[F_SHELSRC +: 2] = 2'b01;
                  end else begin
                     w_c[F_MARYW]        = 1'b1;
                     w_c[F_MARYSRC +: 2] = 2'b01;
                  end
               end
               CLS_MEMR: begin
                  if (w_op == 8'h06) begin
                     w_c[F_SHELW]        = 1'b1;
                     w_c[F_SHELSRC +: 2] = 2'b10;
                  end else if (w_op == 8'h13) begin
                     w_c[F_RAW] = 1'b1;
                  end else begin
                     w_c[F_MARYW]        = 1'b1;
                     w_c[F_MARYSRC +: 2] = 2'b10;
                  end
                  if (w_op == 8'h05) begin
                     w_c[F_SPW]        = 1'b1;
                     w_c[F_SPSRC +: 2] = 2'b10;
                  end
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/WB/HALT FSM,
// opcode latch, retired-instruction counter and status flags.
module control_sequencer
   import cs_pkg::*;
#(
   parameter int OPW  = 5,
   parameter int CW   = 32,
   parameter int CNTW = 16
) (
   input  logic            CLK,
   input  logic            Reset,
   input  logic [OPW-1:0]  OPCODE,
   input  logic            flagbit,
   input  logic            mem_ready,
   input  logic            run_en,
   output logic [CW-1:0]   ctrl,
   output logic [2:0]      state,
   output logic            instr_done,
   output logic            illegal,
   output logic            halted,
   output logic [CNTW-1:0] retired
);

   logic [2:0]      r_state;
   logic [2:0]      w_next;
   logic [OPW:0]    r_op_q;
   logic [CNTW-1:0] r_retired;
   logic            r_illegal;
   logic            w_done;
   logic            w_live_halt;
   logic            w_live_ill;
   cls_e            w_live_cls;
   cls_e            w_q_cls;
   logic [CW-1:0]   w_ctrl;

   assign w_live_cls  = op_class(8'(OPCODE));
   assign w_live_halt = &OPCODE;
   assign w_live_ill  = !w_live_halt && (w_live_cls == CLS_ILL);
   assign w_q_cls     = op_class(8'(r_op_q[OPW:1]));

   always_comb begin
      w_next = S_FETCH;
      w_done = 1'b0;
      case (r_state)
         S_FETCH:  w_next = (run_en && mem_ready) ? S_DECODE : S_FETCH;
         S_DECODE: w_next = (w_live_halt || w_live_ill) ? S_HALT : S_EXEC;
         S_EXEC: begin
            case (w_q_cls)
               CLS_ONE: begin
                  w_next = S_FETCH;
                  w_done = 1'b1;
               end
               CLS_MEMW: begin
                  w_next = mem_ready ? S_FETCH : S_EXEC;
                  w_done = mem_ready;
               end
               CLS_MEMR: w_next = mem_ready ? S_WB : S_EXEC;
               CLS_ALU:  w_next = S_WB;
               default:  w_next = S_FETCH;
            endcase
         end
         S_WB: begin
            w_next = S_FETCH;
            w_done = 1'b1;
         end
         S_HALT:   w_next = S_HALT;
         default:  w_next = S_FETCH;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         r_state   <= S_FETCH;
         r_op_q    <= '0;
         r_retired <= '0;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) begin
            r_op_q <= {OPCODE, flagbit};
            if (w_live_ill) r_illegal <= 1'b1;
         end
         if (w_done) r_retired <= r_retired + CNTW'(1);
      end
   end

   cs_decode #(
      .OPW (OPW),
      .CW  (CW)
   ) u_decode (
      .i_op_q      (r_op_q),
      .i_state     (r_state),
      .i_run_en    (run_en),
      .i_mem_ready (mem_ready),
      .o_ctrl      (w_ctrl)
   );

   // Reset must blank the word even while FETCH would present a read
   assign ctrl       = Reset ? w_ctrl : '0;
   assign instr_done = Reset & w_done;
   assign state      = r_state;
   assign illegal    = r_illegal;
   assign halted     = (r_state == S_HALT);
   assign retired    = r_retired;

endmodule
